// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//   Registered result stage that sits directly after the 4-bit adder/subtractor.
//   Each accepted adder result (S, C, V, M) is turned into one entry
//   {sum, carry/borrow, overflow, zero, negative} and held in a 2-entry skid
//   FIFO. The FIFO hands entries to the consumer with a valid/ready handshake.
//   The stage also keeps a sticky overflow flag and a saturating count of
//   accepted overflow entries.
//
//   Build option:
//     ALU_BORROW_FLAG_EN - when defined, flag_c = c_in ^ m_in. For a subtract
//                          this gives a borrow, so 1 means A < B unsigned.
//                          When undefined, flag_c = c_in unchanged.
//
//   Ports:
//     clk, rst          rising-edge clock, synchronous active-high reset
//     in_valid/in_ready upstream handshake; push = in_valid & in_ready
//     s_in,c_in,v_in,m_in  adder sum, carry, overflow, op select (1 = sub)
//     out_valid/out_ready  downstream handshake; pop = out_valid & out_ready
//     result, flag_c/v/z/n head entry fields
//     sticky_v, ovf_count  overflow history, cleared by clr_sticky
// ---------------------------------------------------------------------------
module alu_result_stage #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s_in,
  input  logic             c_in,
  input  logic             v_in,
  input  logic             m_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n,
  output logic             sticky_v,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_sticky
);

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
    logic             z;
    logic             n;
  } entry_t;

  entry_t [1:0] mem;
  logic         rd_ptr, wr_ptr;
  logic [1:0]   cnt;
  logic         push, pop;
  entry_t       new_entry;
  entry_t       head;

  logic             sticky_nxt;
  logic [CNT_W-1:0] ovf_base, ovf_nxt;

  // Handshake. in_ready only looks at registered occupancy (plus rst), so
  // there is no combinational path from out_ready back to the producer.
  assign in_ready  = ~rst & (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Flags are derived once, when the entry is written.
  always_comb begin
    new_entry   = '0;
    new_entry.s = s_in;
`ifdef ALU_BORROW_FLAG_EN
    new_entry.c = c_in ^ m_in;
`else
    new_entry.c = c_in;
`endif
    new_entry.v = v_in;
    new_entry.z = (s_in == '0);
    new_entry.n = s_in[WIDTH-1];
  end

  // Storage is cleared on reset so the head outputs read 0 afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head   = mem[rd_ptr];
  assign result = head.s;
  assign flag_c = head.c;
  assign flag_v = head.v;
  assign flag_z = head.z;
  assign flag_n = head.n;

  // Overflow history. The clear is applied first and the new overflow is
  // counted on top of it, so a collision leaves sticky_v=1, ovf_count=1.
  always_comb begin
    ovf_base   = clr_sticky ? '0 : ovf_count;
    sticky_nxt = clr_sticky ? 1'b0 : sticky_v;
    ovf_nxt    = ovf_base;
    if (push && v_in) begin
      sticky_nxt = 1'b1;
      if (ovf_base != {CNT_W{1'b1}})
        ovf_nxt = ovf_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_v  <= 1'b0;
      ovf_count <= '0;
    end else begin
      sticky_v  <= sticky_nxt;
      ovf_count <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage
//   Self-checking bench for alu_result_stage. A queue-based reference model
//   tracks the FIFO contents and the overflow history; directed scenarios use
//   constants, the random scenario compares against the model every cycle.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;
  localparam int WIDTH = 4;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, c_in, v_in, m_in;
  logic [WIDTH-1:0] s_in, result;
  logic             out_valid, out_ready, flag_c, flag_v, flag_z, flag_n;
  logic             sticky_v, clr_sticky;
  logic [CNT_W-1:0] ovf_count;

  int checks = 0;
  int failures = 0;

  // model state
  logic [WIDTH+3:0] q[$];   // {s, c, v, z, n}
  bit               m_sticky;
  int               m_ovf;
  bit               m_push;

  alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .s_in(s_in), .c_in(c_in), .v_in(v_in), .m_in(m_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n),
    .sticky_v(sticky_v), .ovf_count(ovf_count), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  function automatic logic exp_c(input logic c, input logic m);
`ifdef ALU_BORROW_FLAG_EN
    return c ^ m;
`else
    return c;
`endif
  endfunction

  // Advance one clock: update the model from the inputs held this cycle,
  // then return at the falling edge where outputs are sampled.
  task automatic step;
    bit rdy, pop;
    rdy    = !rst && (q.size() != 2);
    m_push = in_valid && rdy;
    pop    = (q.size() != 0) && out_ready;
    if (rst) begin
      q.delete();
      m_sticky = 0;
      m_ovf    = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (m_push)
        q.push_back({s_in, exp_c(c_in, m_in), v_in, (s_in == 0), s_in[WIDTH-1]});
      if (clr_sticky) begin
        m_sticky = 0;
        m_ovf    = 0;
      end
      if (m_push && v_in) begin
        m_sticky = 1;
        if (m_ovf < SAT) m_ovf++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit vld, input logic [WIDTH-1:0] s,
                       input bit c, input bit v, input bit m);
    in_valid = vld; s_in = s; c_in = c; v_in = v; m_in = m;
  endtask

  task automatic test_reset;
    rst = 1; out_ready = 1; clr_sticky = 0;
    drive(1, 4'hA, 1, 1, 0);
    step(); step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
    end
    checks++;
    if (sticky_v !== 1'b0 || ovf_count !== '0) begin
      failures++;
      $display("FAIL reset_ovf: sticky=%b cnt=%0d want 0 0", sticky_v, ovf_count);
    end
    checks++;
    if ({result, flag_c, flag_v, flag_z, flag_n} !== '0) begin
      failures++;
      $display("FAIL reset_out: result=%h flags=%b%b%b%b want 0", result,
               flag_c, flag_v, flag_z, flag_n);
    end
    rst = 0; in_valid = 0;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_sub;
    logic want_c;
`ifdef ALU_BORROW_FLAG_EN
    want_c = 1'b0;
`else
    want_c = 1'b1;
`endif
    out_ready = 1;
    drive(1, 4'h0, 1, 0, 1);
    step();
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || result !== 4'h0) begin
      failures++;
      $display("FAIL sub_out: valid=%b result=%h want 1 0", out_valid, result);
    end
    checks++;
    if ({flag_z, flag_n, flag_c, flag_v} !== {1'b1, 1'b0, want_c, 1'b0}) begin
      failures++;
      $display("FAIL sub_flags: zncv=%b%b%b%b want 10%b0", flag_z, flag_n, flag_c,
               flag_v, want_c);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL sub_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 0;
    drive(1, 4'h3, 0, 0, 0); step();
    drive(1, 4'h5, 0, 0, 0); step();
    checks++;
    if (in_ready !== 1'b0 || result !== 4'h3) begin
      failures++;
      $display("FAIL bp_full: in_ready=%b result=%h want 0 3", in_ready, result);
    end
    drive(1, 4'h7, 0, 0, 0); step();
    checks++;
    if (in_ready !== 1'b0 || result !== 4'h3 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold: in_ready=%b result=%h valid=%b want 0 3 1", in_ready,
               result, out_valid);
    end
    out_ready = 1; step();
    checks++;
    if (result !== 4'h5 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_pop1: result=%h in_ready=%b want 5 1", result, in_ready);
    end
    step();
    in_valid = 0;
    checks++;
    if (result !== 4'h7 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_pop2: result=%h valid=%b want 7 1", result, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_overflow_sat;
    out_ready = 1;
    drive(1, 4'h8, 0, 1, 0); step();
    checks++;
    if ({flag_v, flag_n, flag_z} !== 3'b110 || sticky_v !== 1'b1 || ovf_count !== 4'd1) begin
      failures++;
      $display("FAIL ovf_first: vnz=%b%b%b sticky=%b cnt=%0d want 110 1 1", flag_v,
               flag_n, flag_z, sticky_v, ovf_count);
    end
    for (int i = 0; i < 16; i++) step();
    in_valid = 0;
    checks++;
    if (ovf_count !== 4'(SAT) || sticky_v !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sat: cnt=%0d sticky=%b want %0d 1", ovf_count, sticky_v, SAT);
    end
    step();
  endtask

  task automatic test_clear_collision;
    out_ready = 1;
    in_valid = 0; clr_sticky = 1; step();
    clr_sticky = 0;
    checks++;
    if (sticky_v !== 1'b0 || ovf_count !== '0) begin
      failures++;
      $display("FAIL clr_alone1: sticky=%b cnt=%0d want 0 0", sticky_v, ovf_count);
    end
    drive(1, 4'hC, 1, 1, 1);
    for (int i = 0; i < 9; i++) step();
    checks++;
    if (ovf_count !== 4'd9) begin
      failures++;
      $display("FAIL clr_pre: cnt=%0d want 9", ovf_count);
    end
    clr_sticky = 1; step();
    in_valid = 0;
    checks++;
    if (sticky_v !== 1'b1 || ovf_count !== 4'd1) begin
      failures++;
      $display("FAIL clr_collide: sticky=%b cnt=%0d want 1 1", sticky_v, ovf_count);
    end
    step();
    clr_sticky = 0;
    checks++;
    if (sticky_v !== 1'b0 || ovf_count !== '0) begin
      failures++;
      $display("FAIL clr_alone2: sticky=%b cnt=%0d want 0 0", sticky_v, ovf_count);
    end
    step();
  endtask

  task automatic test_reset_full;
    out_ready = 0;
    drive(1, 4'h3, 0, 0, 0); step();
    drive(1, 4'h5, 0, 0, 0); step();
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rf_full: valid=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    rst = 1; step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rf_flush: out_valid=%b want 0", out_valid);
    end
    rst = 0; out_ready = 1;
    drive(1, 4'h9, 0, 0, 0); step();
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || result !== 4'h9) begin
      failures++;
      $display("FAIL rf_first: valid=%b result=%h want 1 9", out_valid, result);
    end
    step();
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      clr_sticky = ($urandom_range(0, 9) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 2) != 0, 4'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom));
      step();
      checks++;
      if (out_valid !== (q.size() != 0) || in_ready !== (!rst && q.size() != 2)) begin
        failures++;
        $display("FAIL rnd_hs[%0d]: valid=%b in_ready=%b want %b %b", i, out_valid,
                 in_ready, q.size() != 0, !rst && q.size() != 2);
      end
      checks++;
      if (sticky_v !== m_sticky || ovf_count !== 4'(m_ovf)) begin
        failures++;
        $display("FAIL rnd_ovf[%0d]: sticky=%b cnt=%0d want %b %0d", i, sticky_v,
                 ovf_count, m_sticky, m_ovf);
      end
      if (q.size() != 0) begin
        checks++;
        if ({result, flag_c, flag_v, flag_z, flag_n} !== q[0]) begin
          failures++;
          $display("FAIL rnd_head[%0d]: got %b want %b", i,
                   {result, flag_c, flag_v, flag_z, flag_n}, q[0]);
        end
      end
    end
  endtask

  initial begin
    rst = 1; in_valid = 0; out_ready = 0; clr_sticky = 0;
    s_in = '0; c_in = 0; v_in = 0; m_in = 0;
    m_sticky = 0; m_ovf = 0; m_push = 0;
    @(negedge clk);
    test_reset();
    test_single_sub();
    test_backpressure();
    test_overflow_sat();
    test_clear_collision();
    test_reset_full();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered stage directly downstream of the 4-bit AdderSubtractor.
- Captures the adder's sum S, carry C and overflow V, plus the operation select M, and derives zero and negative flags.
- Buffers results in a 2-entry skid FIFO with valid/ready handshake toward the consumer (register file / display).
- Maintains a sticky overflow flag and a saturating overflow event counter.

Parameters:
- WIDTH, 4, data width of adder sum S.
- CNT_W, 4, width of overflow event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  adder result present on s_in/c_in/v_in/m_in.
- in_ready  output  1  stage can accept an entry this cycle.
- s_in  input  WIDTH  adder sum S.
- c_in  input  1  adder carry-out C.
- v_in  input  1  adder overflow V.
- m_in  input  1  operation select M (0 = add, 1 = subtract).
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer takes head entry.
- result  output  WIDTH  head entry sum.
- flag_c  output  1  head entry carry/borrow.
- flag_v  output  1  head entry overflow.
- flag_z  output  1  head entry zero (result == 0).
- flag_n  output  1  head entry negative (result MSB).
- sticky_v  output  1  an overflow has been accepted since the last clear.
- ovf_count  output  CNT_W  number of accepted overflow entries, saturating.
- clr_sticky  input  1  clears sticky_v and ovf_count.

Behaviour:
- Clocking and reset: single clock domain. rst is synchronous and active-high and is sampled only on the rising edge of clk.

- Transfer rules:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Each entry holds {s_in, flag_c, v_in, z, n}. z and n are computed from s_in at push time.

- Occupancy count cnt (0..2), registered:
  - in_ready = ~rst & (cnt != 2). It depends only on registered state and has no combinational path from out_ready.
  - out_valid = (cnt != 0).
  - result and flags are driven from the head entry.

- Latency and ordering:
  - An entry pushed in cycle N appears at the outputs in cycle N+1 when the stage was empty.
  - Throughput is 1 entry per cycle with out_ready held high.
  - Strict FIFO order.

- Simultaneous push and pop:
  - cnt=1: cnt stays 1 and the new entry becomes head next cycle.
  - cnt=2: push is impossible (in_ready=0). The pop makes cnt=1 and in_ready=1 next cycle.
  - cnt=0: pop is impossible. A push gives cnt=1.

- in_valid with in_ready=0: no capture. The upstream must hold its data; the stage does not check this.

- Output values while out_valid=0: unchecked, except that they are all 0 after reset.

- Sticky overflow flag and counter, on each cycle:
  - push & v_in: sticky_v <= 1 and ovf_count increments, saturating at 2^CNT_W-1.
  - clr_sticky alone: sticky_v <= 0 and ovf_count <= 0.
  - clr_sticky in the same cycle as push & v_in: sticky_v = 1 and ovf_count = 1 (the clear is applied first, then the count).

- Reset values: cnt=0, out_valid=0, result=0, all flags=0, sticky_v=0, ovf_count=0. in_ready is 0 while rst is high.

- Reset mid-operation: all buffered entries are discarded with no pop. In the cycle after rst deasserts, out_valid=0 and in_ready=1.

Optional Feature:
- Macro: ALU_BORROW_FLAG_EN.
- Defined: flag_c = c_in ^ m_in, i.e. borrow semantics for subtraction (1 means A<B unsigned when M=1).
- Undefined: flag_c = c_in unmodified.
- Either way the conversion is applied at push time; all other behaviour is identical.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 → in_ready=0, out_valid=0, sticky_v=0, ovf_count=0. After release, in_ready=1 next cycle.
- Single subtract 5-5: s_in=0000, c_in=1, v_in=0, m_in=1, out_ready=1 → next cycle out_valid=1, result=0000, flag_z=1, flag_n=0, flag_c=1 (macro undefined) or 0 (macro defined). out_valid=0 the following cycle.
- Backpressure with out_ready=0: push 0x3, 0x5, 0x7 on consecutive cycles → 0x3 and 0x5 accepted, in_ready=0 after the second push, 0x7 held upstream. Raise out_ready → pops 0x3 then 0x5, and 0x7 is accepted and popped third.
- Overflow 7+1: s_in=1000, c_in=0, v_in=1, m_in=0 → flag_v=1, flag_n=1, sticky_v=1, ovf_count=1. Then 16 more overflow pushes → ovf_count saturates at 15.
- Clear/overflow collision: clr_sticky=1 in the same cycle as an overflow push with ovf_count=9 → sticky_v=1, ovf_count=1. clr_sticky alone next cycle → 0, 0.
- Reset while full: cnt=2 holding 0x3/0x5, assert rst 1 cycle → out_valid=0 and nothing popped. After release, pushing 0x9 yields result=0x9 first.
